// File: rtl/trap_controller_if.sv
// CSR-file side of the user-mode trap controller: parallel CSR reads in,
// simultaneous uepc/ucause/utval write and normal write port out.
interface trap_controller_if;
    logic [31:0] ustatus;
    logic [31:0] uie;
    logic [31:0] utvec;
    logic [31:0] uepc;

    logic        csr_simu_write;
    logic [31:0] csr_uepc_data;
    logic [31:0] csr_ucause_data;
    logic [31:0] csr_utval_data;

    logic        csr_write;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;

    modport master (
        input  ustatus, uie, utvec, uepc,
        output csr_simu_write, csr_uepc_data, csr_ucause_data, csr_utval_data,
        output csr_write, csr_write_address, csr_write_data
    );

    modport slave (
        output ustatus, uie, utvec, uepc,
        input  csr_simu_write, csr_uepc_data, csr_ucause_data, csr_utval_data,
        input  csr_write, csr_write_address, csr_write_data
    );
endinterface

// File: rtl/trap_controller.sv
// User-mode trap sequencer: turns exceptions, gated user interrupts and uret
// into a stalled CSR save / ustatus update / PC redirect sequence.
module trap_controller #(
    parameter logic [11:0] USTATUS_ADDR = 12'd0,
    parameter logic [4:0]  CODE_USI     = 5'd0,
    parameter logic [4:0]  CODE_UTI     = 5'd4,
    parameter logic [4:0]  CODE_UEI     = 5'd8
) (
    input  logic                core_clock,
    input  logic                reset,
    input  logic [31:0]         pc,
    input  logic                exc_valid,
    input  logic [30:0]         exc_cause,
    input  logic [31:0]         exc_tval,
    input  logic                uret_valid,
    input  logic                irq_software,
    input  logic                irq_timer,
    input  logic                irq_external,
    trap_controller_if.master   csr,
    output logic                stall_request,
    output logic                pc_redirect,
    output logic [31:0]         pc_redirect_target
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE     = 2'd1,
        STATUS   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [31:0] l_pc;
    logic [31:0] l_cause;
    logic [31:0] l_tval;
    logic [31:0] l_ustatus;
    logic [31:0] l_utvec;
    logic [31:0] l_uepc;
    logic [4:0]  l_code;
    logic        l_is_irq;
    logic        l_is_uret;

    logic        take_ext, take_sw, take_tm;
    logic        accept;
    logic        evt_is_irq, evt_is_uret;
    logic [4:0]  evt_code;
    logic [31:0] trap_base;

    logic unused_uie_bits;
    assign unused_uie_bits = ^{csr.uie[31:9], csr.uie[7:5], csr.uie[3:1]};

    always_comb begin
        take_ext = csr.ustatus[0] & csr.uie[8] & irq_external;
        take_sw  = csr.ustatus[0] & csr.uie[0] & irq_software;
        take_tm  = csr.ustatus[0] & csr.uie[4] & irq_timer;
        accept   = (state == IDLE) & ~reset
                 & (exc_valid | take_ext | take_sw | take_tm | uret_valid);

        evt_is_irq  = 1'b0;
        evt_is_uret = 1'b0;
        evt_code    = '0;
        if (exc_valid) begin
            evt_is_irq = 1'b0;
        end else if (take_ext) begin
            evt_is_irq = 1'b1;
            evt_code   = CODE_UEI;
        end else if (take_sw) begin
            evt_is_irq = 1'b1;
            evt_code   = CODE_USI;
        end else if (take_tm) begin
            evt_is_irq = 1'b1;
            evt_code   = CODE_UTI;
        end else begin
            evt_is_uret = uret_valid;
        end
    end

    always_ff @(posedge core_clock) begin
        if (reset) begin
            state     <= IDLE;
            l_pc      <= '0;
            l_cause   <= '0;
            l_tval    <= '0;
            l_ustatus <= '0;
            l_utvec   <= '0;
            l_uepc    <= '0;
            l_code    <= '0;
            l_is_irq  <= 1'b0;
            l_is_uret <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                l_pc      <= pc;
                l_tval    <= evt_is_irq ? 32'd0 : exc_tval;
                l_cause   <= evt_is_irq ? {1'b1, 26'd0, evt_code} : {1'b0, exc_cause};
                l_ustatus <= csr.ustatus;
                l_utvec   <= csr.utvec;
                l_uepc    <= csr.uepc;
                l_code    <= evt_code;
                l_is_irq  <= evt_is_irq;
                l_is_uret <= evt_is_uret;
            end
        end
    end

    assign trap_base = l_utvec & ~32'd3;

    always_comb begin
        state_next             = state;
        stall_request          = (state != IDLE) | accept;
        pc_redirect            = 1'b0;
        pc_redirect_target     = '0;
        csr.csr_simu_write     = 1'b0;
        csr.csr_uepc_data      = '0;
        csr.csr_ucause_data    = '0;
        csr.csr_utval_data     = '0;
        csr.csr_write          = 1'b0;
        csr.csr_write_address  = '0;
        csr.csr_write_data     = '0;

        unique case (state)
            IDLE: begin
                if (accept) state_next = evt_is_uret ? STATUS : SAVE;
            end
            SAVE: begin
                csr.csr_simu_write  = 1'b1;
                csr.csr_uepc_data   = l_pc;
                csr.csr_ucause_data = l_cause;
                csr.csr_utval_data  = l_tval;
                state_next          = STATUS;
            end
            STATUS: begin
                csr.csr_write         = 1'b1;
                csr.csr_write_address = USTATUS_ADDR;
                csr.csr_write_data    = l_ustatus;
                // Trap: UPIE <- UIE, UIE <- 0.  uret: UIE <- UPIE, UPIE <- 1.
                if (l_is_uret) begin
                    csr.csr_write_data[0] = l_ustatus[4];
                    csr.csr_write_data[4] = 1'b1;
                end else begin
                    csr.csr_write_data[4] = l_ustatus[0];
                    csr.csr_write_data[0] = 1'b0;
                end
                state_next = REDIRECT;
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                if (l_is_uret)
                    pc_redirect_target = l_uepc;
                else if (l_is_irq && (l_utvec[1:0] == 2'd1))
                    pc_redirect_target = trap_base + {25'd0, l_code, 2'b00};
                else
                    pc_redirect_target = trap_base;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed-vector bench for trap_controller: trap, vectored interrupt,
// priority, uret, reset abort, busy-drop and back-to-back sequences.
module tb_trap_controller;

    logic        core_clock;
    logic        reset;
    logic [31:0] pc;
    logic        exc_valid;
    logic [30:0] exc_cause;
    logic [31:0] exc_tval;
    logic        uret_valid;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic        stall_request;
    logic        pc_redirect;
    logic [31:0] pc_redirect_target;

    int checks   = 0;
    int failures = 0;

    trap_controller_if csr ();

    trap_controller dut (
        .core_clock         (core_clock),
        .reset              (reset),
        .pc                 (pc),
        .exc_valid          (exc_valid),
        .exc_cause          (exc_cause),
        .exc_tval           (exc_tval),
        .uret_valid         (uret_valid),
        .irq_software       (irq_software),
        .irq_timer          (irq_timer),
        .irq_external       (irq_external),
        .csr                (csr),
        .stall_request      (stall_request),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target)
    );

    initial core_clock = 1'b0;
    always #5 core_clock = ~core_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    {31'd0, stall_request}, 32'd0);
        check({tag, "_redir"},    {31'd0, pc_redirect}, 32'd0);
        check({tag, "_target"},   pc_redirect_target, 32'd0);
        check({tag, "_simu"},     {31'd0, csr.csr_simu_write}, 32'd0);
        check({tag, "_uepc_d"},   csr.csr_uepc_data, 32'd0);
        check({tag, "_ucause_d"}, csr.csr_ucause_data, 32'd0);
        check({tag, "_utval_d"},  csr.csr_utval_data, 32'd0);
        check({tag, "_we"},       {31'd0, csr.csr_write}, 32'd0);
        check({tag, "_waddr"},    {20'd0, csr.csr_write_address}, 32'd0);
        check({tag, "_wdata"},    csr.csr_write_data, 32'd0);
    endtask

    task automatic expect_save(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_cause, input logic [31:0] e_tval);
        check({tag, "_save_simu"},  {31'd0, csr.csr_simu_write}, 32'd1);
        check({tag, "_save_uepc"},  csr.csr_uepc_data, e_pc);
        check({tag, "_save_cause"}, csr.csr_ucause_data, e_cause);
        check({tag, "_save_tval"},  csr.csr_utval_data, e_tval);
        check({tag, "_save_we"},    {31'd0, csr.csr_write}, 32'd0);
        check({tag, "_save_stall"}, {31'd0, stall_request}, 32'd1);
        check({tag, "_save_redir"}, {31'd0, pc_redirect}, 32'd0);
    endtask

    // Checks STATUS now, then REDIRECT one cycle later; returns in REDIRECT.
    task automatic expect_tail(input string tag, input logic [31:0] e_status,
                               input logic [31:0] e_target);
        check({tag, "_st_we"},     {31'd0, csr.csr_write}, 32'd1);
        check({tag, "_st_addr"},   {20'd0, csr.csr_write_address}, 32'd0);
        check({tag, "_st_data"},   csr.csr_write_data, e_status);
        check({tag, "_st_simu"},   {31'd0, csr.csr_simu_write}, 32'd0);
        check({tag, "_st_uepc_d"}, csr.csr_uepc_data, 32'd0);
        check({tag, "_st_stall"},  {31'd0, stall_request}, 32'd1);
        check({tag, "_st_redir"},  {31'd0, pc_redirect}, 32'd0);
        tick();
        check({tag, "_rd_redir"},  {31'd0, pc_redirect}, 32'd1);
        check({tag, "_rd_target"}, pc_redirect_target, e_target);
        check({tag, "_rd_we"},     {31'd0, csr.csr_write}, 32'd0);
        check({tag, "_rd_wdata"},  csr.csr_write_data, 32'd0);
        check({tag, "_rd_stall"},  {31'd0, stall_request}, 32'd1);
    endtask

    task automatic expect_trap(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_cause, input logic [31:0] e_tval,
                               input logic [31:0] e_status, input logic [31:0] e_target);
        expect_save(tag, e_pc, e_cause, e_tval);
        tick();
        expect_tail(tag, e_status, e_target);
    endtask

    initial begin
        reset        = 1'b1;
        pc           = '0;
        exc_valid    = 1'b1;
        exc_cause    = '0;
        exc_tval     = '0;
        uret_valid   = 1'b0;
        irq_software = 1'b0;
        irq_timer    = 1'b0;
        irq_external = 1'b0;
        csr.ustatus  = '0;
        csr.uie      = '0;
        csr.utvec    = '0;
        csr.uepc     = '0;

        // Reset: outputs zero even with an exception pending.
        tick();
        check_all_zero("reset");
        exc_valid = 1'b0;
        reset     = 1'b0;
        tick();
        check_all_zero("idle");

        // Exception, direct mode.
        csr.utvec = 32'h0000_0400; csr.ustatus = 32'h1;
        pc = 32'h0000_0100; exc_cause = 31'd2; exc_tval = 32'hDEAD_BEEF; exc_valid = 1'b1;
        #1 check("exc_accept_stall", {31'd0, stall_request}, 32'd1);
        check("exc_accept_nosimu", {31'd0, csr.csr_simu_write}, 32'd0);
        tick();
        exc_valid = 1'b0; pc = 32'hFFFF_FFF0; csr.utvec = 32'h1234_5679; csr.ustatus = '0;
        exc_tval = 32'h0; exc_cause = 31'h7;
        expect_trap("exc", 32'h100, 32'h2, 32'hDEAD_BEEF, 32'h10, 32'h400);
        tick();
        check("exc_done_stall", {31'd0, stall_request}, 32'd0);
        check("exc_done_redir", {31'd0, pc_redirect}, 32'd0);

        // Vectored timer interrupt.
        csr.utvec = 32'h0000_0801; csr.ustatus = 32'h1; csr.uie = 32'h10;
        pc = 32'h0000_0200; irq_timer = 1'b1;
        #1 check("tmr_accept_stall", {31'd0, stall_request}, 32'd1);
        tick();
        irq_timer = 1'b0; csr.ustatus = '0; csr.utvec = 32'h0;
        expect_trap("tmr", 32'h200, 32'h8000_0004, 32'h0, 32'h10, 32'h810);
        tick();
        check("tmr_done_stall", {31'd0, stall_request}, 32'd0);

        // Same setup with UIE clear: nothing happens.
        csr.utvec = 32'h0000_0801; csr.ustatus = 32'h0; irq_timer = 1'b1;
        #1 check("gated_stall0", {31'd0, stall_request}, 32'd0);
        tick();
        check("gated_stall1", {31'd0, stall_request}, 32'd0);
        check("gated_simu", {31'd0, csr.csr_simu_write}, 32'd0);

        // Priority: exception wins over external, timer and uret.
        csr.ustatus = 32'h1; csr.uie = 32'h110; irq_external = 1'b1; uret_valid = 1'b1;
        exc_valid = 1'b1; exc_cause = 31'h0D; exc_tval = 32'h55; pc = 32'h300;
        tick();
        exc_valid = 1'b0; uret_valid = 1'b0; csr.ustatus = '0;
        expect_trap("prio_exc", 32'h300, 32'hD, 32'h55, 32'h10, 32'h800);
        tick();
        check("prio_masked_stall", {31'd0, stall_request}, 32'd0);
        csr.ustatus = 32'h1; pc = 32'h304;
        #1 check("prio_ext_stall", {31'd0, stall_request}, 32'd1);
        tick();
        csr.ustatus = '0;
        expect_trap("prio_ext", 32'h304, 32'h8000_0008, 32'h0, 32'h10, 32'h820);
        irq_external = 1'b0; irq_timer = 1'b0;
        tick();
        check("prio_done_stall", {31'd0, stall_request}, 32'd0);

        // uret.
        csr.ustatus = 32'h10; csr.uepc = 32'h204; csr.utvec = 32'h400; uret_valid = 1'b1;
        #1 check("uret_accept_stall", {31'd0, stall_request}, 32'd1);
        tick();
        uret_valid = 1'b0; csr.uepc = 32'hABC; csr.ustatus = '0;
        expect_tail("uret", 32'h11, 32'h204);
        tick();
        check("uret_done_stall", {31'd0, stall_request}, 32'd0);

        // Reset during STATUS aborts; a later exception runs in full.
        csr.utvec = 32'h400; csr.ustatus = 32'h1; pc = 32'h100;
        exc_cause = 31'd2; exc_tval = 32'hDEAD_BEEF; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        expect_save("rst", 32'h100, 32'h2, 32'hDEAD_BEEF);
        tick();
        check("rst_in_status", {31'd0, csr.csr_write}, 32'd1);
        reset = 1'b1;
        tick();
        check_all_zero("rst_abort");
        reset = 1'b0;
        tick();
        check("rst_after_redir", {31'd0, pc_redirect}, 32'd0);
        check("rst_after_stall", {31'd0, stall_request}, 32'd0);
        pc = 32'h140; exc_cause = 31'd5; exc_tval = 32'h77; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        expect_trap("post_rst", 32'h140, 32'h5, 32'h77, 32'h10, 32'h400);
        tick();
        check("post_rst_stall", {31'd0, stall_request}, 32'd0);

        // Software interrupt pulsed only during SAVE is dropped.
        csr.ustatus = 32'h1; csr.uie = 32'h1; pc = 32'h180;
        exc_cause = 31'd1; exc_tval = 32'h11; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0; irq_software = 1'b1;
        expect_save("busy", 32'h180, 32'h1, 32'h11);
        tick();
        irq_software = 1'b0;
        expect_tail("busy", 32'h10, 32'h400);
        tick();
        check("busy_dropped0", {31'd0, stall_request}, 32'd0);
        tick();
        check("busy_dropped1", {31'd0, stall_request}, 32'd0);
        check("busy_dropped_simu", {31'd0, csr.csr_simu_write}, 32'd0);

        // Back-to-back: timer held through the trap is taken right after REDIRECT.
        csr.utvec = 32'h401; csr.ustatus = 32'h1; csr.uie = 32'h10; pc = 32'h1C0;
        exc_cause = 31'd3; exc_tval = 32'h22; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0; irq_timer = 1'b1;
        expect_trap("b2b_exc", 32'h1C0, 32'h3, 32'h22, 32'h10, 32'h400);
        pc = 32'h1C4;
        tick();
        check("b2b_accept_stall", {31'd0, stall_request}, 32'd1);
        check("b2b_accept_redir", {31'd0, pc_redirect}, 32'd0);
        tick();
        irq_timer = 1'b0;
        expect_trap("b2b_tmr", 32'h1C4, 32'h8000_0004, 32'h0, 32'h10, 32'h410);
        tick();
        check("b2b_done_stall", {31'd0, stall_request}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

User-mode (N-extension) trap sequencer sitting directly upstream of the CSR register file. It accepts synchronous exceptions, gated user interrupts and `uret` from the core and turns each into a short, stalled write sequence. The sequence saves `uepc`/`ucause`/`utval` through the CSR file's simultaneous-write path, then updates `ustatus` through the normal write port. Finally it redirects the PC to the handler (computed from `utvec`) or back to `uepc`.

## Interface
- `USTATUS_ADDR`, 12'd0: CSR address used for the ustatus write.
- `CODE_USI`, 0 / `CODE_UTI`, 4 / `CODE_UEI`, 8: interrupt cause codes.
- `core_clock` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: PC of the instruction currently being committed.
- `exc_valid` in 1: synchronous exception on `pc`.
- `exc_cause` in 31: exception code.
- `exc_tval` in 32: faulting address/instruction.
- `uret_valid` in 1: `uret` being committed.
- `irq_software`, `irq_timer`, `irq_external` in 1 each: level interrupt requests.
- `ustatus`, `uie`, `utvec`, `uepc` in 32 each: current CSR values from the CSR file's parallel read ports.
- `csr_simu_write` out 1: strobe for the simultaneous uepc/ucause/utval write.
- `csr_uepc_data`, `csr_ucause_data`, `csr_utval_data` out 32 each: data for that write.
- `csr_write` out 1: normal CSR write enable.
- `csr_write_address` out 12: normal CSR write address.
- `csr_write_data` out 32: normal CSR write data.
- `stall_request` out 1: freeze fetch/commit.
- `pc_redirect` out 1: one-cycle PC load.
- `pc_redirect_target` out 32: new PC.

## Operation
- **States:** IDLE, SAVE, STATUS, REDIRECT.
- **Acceptance:** events are sampled only in IDLE.
- **Priority:** `exc_valid` > external > software > timer > `uret_valid`.
- **Interrupt gating:** an interrupt is eligible when `ustatus[0]` (UIE) = 1 and its `uie` bit (0 USIE, 4 UTIE, 8 UEIE) = 1 and its request line is high.
- **Latching on acceptance:** `pc`, cause, tval, `ustatus`, `utvec` and `uepc` are captured into internal registers. All later outputs use only the latched values, so the CSR file's write-back never races the sequence.
- **Cause and tval:**
  - Exception: cause = {1'b0, `exc_cause`}, tval = `exc_tval`.
  - Interrupt: cause = {1'b1, 26'b0, code[4:0]}, tval = 0.
- **Trap path:** IDLE → SAVE → STATUS → REDIRECT → IDLE.
  - SAVE: `csr_simu_write`=1, `csr_uepc_data`=latched pc, plus latched cause and tval.
  - STATUS: `csr_write`=1, address `USTATUS_ADDR`, data = latched ustatus with bit4 (UPIE) ← bit0 and bit0 ← 0.
- **uret path:** IDLE → STATUS → REDIRECT → IDLE.
  - STATUS data = latched ustatus with bit0 ← bit4 and bit4 ← 1.
  - Target = latched uepc.
- **Trap target:**
  - base = `utvec & ~3`.
  - If `utvec[1:0]`==1 and the event is an interrupt: target = base + (code << 2), 32-bit wrap-around.
  - Modes 0, 2, 3, and all exceptions: target = base.
- **Output defaults:** all strobes are 0 outside their state, and data outputs are 0 when their strobe is 0.

## Timing
- **Reset:** state = IDLE; every output = 0 at the first `core_clock` edge with `reset` high. Reset in any state aborts the sequence with no further strobes.
- **`stall_request`:** combinational = (state != IDLE) | event accepted this cycle. It rises in the acceptance cycle and falls in the cycle after REDIRECT.
- **Trap latency:** acceptance edge → SAVE (1 cycle) → STATUS (1) → REDIRECT (1). `pc_redirect` is high exactly one cycle, 3 cycles after acceptance.
- **uret latency:** `pc_redirect` is 2 cycles after acceptance.
- **Events outside IDLE:** ignored and not queued. Level interrupts re-present themselves; the core must hold `exc_valid`/`uret_valid` while `stall_request` is high.
- **Simultaneous events:** only the highest-priority event is taken; lower ones are dropped for that acceptance.
- **Back-to-back:** an event present in the cycle after REDIRECT (state IDLE) is accepted immediately, so the minimum gap is 0 idle cycles.

## Test plan
- **Exception, direct mode:** `utvec`=0x0000_0400, `exc_valid`=1, `exc_cause`=2, `pc`=0x0000_0100, `exc_tval`=0xDEAD_BEEF, `ustatus`=0x1.
  - Expect SAVE with uepc=0x100, ucause=0x2, utval=0xDEADBEEF.
  - Then STATUS write 0x10 to address 0.
  - Then redirect to 0x400 at cycle 3.
- **Vectored timer interrupt:** `utvec`=0x0000_0801, `ustatus`=0x1, `uie`=0x10, `irq_timer`=1.
  - Expect ucause=0x8000_0004, utval=0, target 0x810.
  - The same setup with `ustatus`=0 must produce no stall.
- **Priority:** exception + external + timer + uret all asserted → cause from `exc_cause`, target = base.
  - Then drop the exception, re-enable UIE → cause 0x8000_0008.
- **uret:** latched `uepc`=0x0000_0204, `ustatus`=0x10.
  - Expect no simu write, STATUS write 0x11, redirect to 0x204 at cycle 2.
- **Reset during STATUS:** assert `reset` for one cycle.
  - Expect no `pc_redirect`, `stall_request`=0, all outputs 0 after the edge.
  - A subsequent exception runs the full 3-cycle sequence.
- **Events while busy:** pulse `irq_software` (enabled) only while in SAVE → no second sequence.
  - A held request at REDIRECT+1 is accepted immediately, giving back-to-back traps.
